// File: rtl/ofdm_rx_ctrl_pkg.sv
// Shared types for the OFDM RX frame sequencer.
package ofdm_rx_ctrl_pkg;

  localparam int unsigned state_width_c = 3;

  typedef enum logic [state_width_c-1:0] {
    StIdle,
    StInit,
    StSearch,
    StAlign,
    StReceive,
    StDone
  } state_e;

endpackage

// File: rtl/ofdm_rx_symbol_timer.sv
// In-symbol sample index and symbol counters with FFT-window decode.
module ofdm_rx_symbol_timer #(
  parameter int unsigned symbol_length_c     = 320,
  parameter int unsigned raw_symbol_length_c = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       valid,
  input  logic [7:0] num_symbols,
  output logic       symbol_start,
  output logic       fft_window,
  output logic       last_sample
);

  localparam int unsigned idx_width_c = $clog2(symbol_length_c);
  localparam logic [idx_width_c-1:0] idx_last_c  = idx_width_c'(symbol_length_c - 1);
  localparam logic [idx_width_c-1:0] fft_first_c =
      idx_width_c'(symbol_length_c - raw_symbol_length_c);

  logic [idx_width_c-1:0] idx_q, idx_d;
  logic [7:0]             sym_q, sym_d;
  logic [7:0]             sym_last;
  logic                   wrap;

  // A frame length of 0 symbols behaves as a single symbol.
  assign sym_last = (num_symbols == 8'd0) ? 8'd0 : num_symbols - 8'd1;
  assign wrap     = (idx_q == idx_last_c);

  always_comb begin
    idx_d = idx_q;
    sym_d = sym_q;
    if (clear) begin
      idx_d = '0;
      sym_d = '0;
    end else if (valid) begin
      if (wrap) begin
        idx_d = '0;
        sym_d = sym_q + 8'd1;
      end else begin
        idx_d = idx_q + idx_width_c'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      sym_q <= '0;
    end else begin
      idx_q <= idx_d;
      sym_q <= sym_d;
    end
  end

  assign symbol_start = valid && (idx_q == '0);
  assign fft_window   = valid && (idx_q >= fft_first_c);
  assign last_sample  = valid && wrap && (sym_q == sym_last);

endmodule

// File: rtl/ofdm_rx_ctrl.sv
// OFDM RX frame sequencer: init, signal search, coarse alignment, symbol timing, frame end.
module ofdm_rx_ctrl
  import ofdm_rx_ctrl_pkg::*;
#(
  parameter int unsigned sample_bit_width_c  = 12,
  parameter int unsigned symbol_length_c     = 320,
  parameter int unsigned raw_symbol_length_c = 256,
  parameter int unsigned init_cycles_c       = 4,
  parameter int unsigned level_hits_c        = 8,
  parameter int unsigned timeout_width_c     = 20
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [sample_bit_width_c-1:0] cfg_min_level,
  input  logic [7:0]                    cfg_num_symbols,
  input  logic [timeout_width_c-1:0]    cfg_timeout,
  input  logic                          rx_data_valid,
  input  logic [sample_bit_width_c-1:0] rx_level,
  input  logic                          coarse_found,
  output logic                          sys_init,
  output logic [sample_bit_width_c-1:0] min_level,
  output logic                          dp_enable,
  output logic                          symbol_start,
  output logic                          fft_window,
  output logic                          frame_start,
  output logic                          frame_done,
  output logic                          timeout_err,
  output logic                          busy
);

  localparam int unsigned init_width_c = $clog2(init_cycles_c + 1);
  localparam int unsigned hit_width_c  = $clog2(level_hits_c + 1);
  localparam logic [init_width_c-1:0] init_last_c = init_width_c'(init_cycles_c - 1);
  localparam logic [hit_width_c-1:0]  hit_last_c  = hit_width_c'(level_hits_c - 1);

  state_e state_q, state_d;

  logic [init_width_c-1:0]       init_cnt_q;
  logic [hit_width_c-1:0]        hit_cnt_q;
  logic [timeout_width_c-1:0]    to_cnt_q, to_next, timeout_q;
  logic [sample_bit_width_c-1:0] min_level_q;
  logic [7:0]                    num_sym_q;

  logic arm, level_hit, coarse_hit, to_expire;
  logic tmr_clear, tmr_valid, tmr_symbol_start, tmr_fft_window, tmr_last_sample;

  logic sys_init_q, dp_enable_q, symbol_start_q, fft_window_q;
  logic frame_start_q, frame_done_q, timeout_err_q, busy_q;
  logic sys_init_d, dp_enable_d, symbol_start_d, fft_window_d;
  logic frame_start_d, frame_done_d, timeout_err_d, busy_d;

  assign arm        = (state_q == StIdle) && start && !abort;
  assign level_hit  = (rx_level >= min_level_q);
  assign coarse_hit = (state_q == StAlign) && rx_data_valid && coarse_found;
  assign to_next    = to_cnt_q + timeout_width_c'(1);
  assign to_expire  = rx_data_valid && (timeout_q != '0) && (to_next == timeout_q);

  // The coarse-alignment sample is in-symbol index 0, so the timer counts it too.
  assign tmr_clear = !(state_q inside {StAlign, StReceive});
  assign tmr_valid = !abort && rx_data_valid && ((state_q == StReceive) || coarse_hit);

  ofdm_rx_symbol_timer #(
    .symbol_length_c     (symbol_length_c),
    .raw_symbol_length_c (raw_symbol_length_c)
  ) u_symbol_timer (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .clear        (tmr_clear),
    .valid        (tmr_valid),
    .num_symbols  (num_sym_q),
    .symbol_start (tmr_symbol_start),
    .fft_window   (tmr_fft_window),
    .last_sample  (tmr_last_sample)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start) state_d = StInit;
        StInit:    if (init_cnt_q == init_last_c) state_d = StSearch;
        StSearch: begin
          if (to_expire) begin
            state_d = StDone;
          end else if (rx_data_valid && level_hit && (hit_cnt_q == hit_last_c)) begin
            state_d = StAlign;
          end
        end
        // Coarse alignment takes priority over a timeout on the same sample.
        StAlign: begin
          if (coarse_hit) begin
            state_d = StReceive;
          end else if (to_expire) begin
            state_d = StDone;
          end
        end
        StReceive: if (tmr_last_sample) state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sys_init_d     = (state_d == StInit);
    busy_d         = (state_d != StIdle);
    dp_enable_d    = state_d inside {StSearch, StAlign, StReceive};
    frame_start_d  = coarse_hit && !abort;
    frame_done_d   = (state_d == StDone);
    symbol_start_d = tmr_symbol_start;
    fft_window_d   = tmr_fft_window;
    timeout_err_d  = timeout_err_q;
    if (arm) begin
      timeout_err_d = 1'b0;
    end
    if ((state_d == StDone) && (state_q inside {StSearch, StAlign})) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      init_cnt_q  <= '0;
      hit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= '0;
      min_level_q <= '0;
      num_sym_q   <= '0;
    end else begin
      init_cnt_q <= (state_q == StInit) ? init_cnt_q + init_width_c'(1) : '0;
      if (state_q != StSearch) begin
        hit_cnt_q <= '0;
      end else if (rx_data_valid) begin
        hit_cnt_q <= level_hit ? hit_cnt_q + hit_width_c'(1) : '0;
      end
      if (!(state_q inside {StSearch, StAlign})) begin
        to_cnt_q <= '0;
      end else if (rx_data_valid) begin
        to_cnt_q <= to_next;
      end
      if (arm) begin
        min_level_q <= cfg_min_level;
        num_sym_q   <= cfg_num_symbols;
        timeout_q   <= cfg_timeout;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sys_init_q     <= 1'b0;
      dp_enable_q    <= 1'b0;
      symbol_start_q <= 1'b0;
      fft_window_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sys_init_q     <= sys_init_d;
      dp_enable_q    <= dp_enable_d;
      symbol_start_q <= symbol_start_d;
      fft_window_q   <= fft_window_d;
      frame_start_q  <= frame_start_d;
      frame_done_q   <= frame_done_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
    end
  end

  assign sys_init     = sys_init_q;
  assign min_level    = min_level_q;
  assign dp_enable    = dp_enable_q;
  assign symbol_start = symbol_start_q;
  assign fft_window   = fft_window_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign busy         = busy_q;

endmodule
